// File: rtl/led_pattern_pwm.sv
// LED pattern generator: prescaled step events drive one of four patterns
// (count / walk / bounce / all-on), gated by a free-running PWM brightness compare.
module led_pattern_pwm #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int STEP_HZ     = 2,
    parameter int NUM_LEDS    = 8,
    parameter int PWM_BITS    = 3,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                hold,
    output logic [NUM_LEDS-1:0] led,
    output logic                step
);

    localparam int DIV = CLK_FREQ_HZ / STEP_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]       PRESC_MAX = PW'(DIV - 1);
    localparam logic [NUM_LEDS-1:0] LED_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_ALL    = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [PW-1:0]       presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    mode_e               mode_q, mode_d;
    dir_e                dir_q, dir_d;
    logic                step_q, step_d;

    logic                mode_chg;
    logic                step_evt;
    logic                pwm_en;
    logic [NUM_LEDS-1:0] lit;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        mode_d    = mode_e'(mode);
        presc_d   = presc_q;
        pattern_d = pattern_q;
        dir_d     = dir_q;
        pwm_d     = pwm_q + PWM_BITS'(1);

        mode_chg = (mode_d != mode_q);
        step_evt = !mode_chg && !hold && (presc_q == PRESC_MAX);
        step_d   = step_evt;

        if (mode_chg) begin
            // A mode switch restarts the pattern and beats any step due on this edge.
            presc_d = '0;
            dir_d   = DIR_UP;
            unique case (mode_d)
                MODE_COUNT:  pattern_d = '0;
                MODE_WALK,
                MODE_BOUNCE: pattern_d = NUM_LEDS'(1);
                MODE_ALL:    pattern_d = '1;
            endcase
        end else if (!hold) begin
            presc_d = step_evt ? '0 : presc_q + PW'(1);
            if (step_evt) begin
                unique case (mode_q)
                    MODE_COUNT: pattern_d = pattern_q + NUM_LEDS'(1);
                    MODE_WALK:  pattern_d = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
                    MODE_BOUNCE: begin
                        if (dir_q == DIR_UP) begin
                            if (pattern_q[NUM_LEDS-1]) begin
                                pattern_d = pattern_q >> 1;
                                dir_d     = DIR_DOWN;
                            end else begin
                                pattern_d = pattern_q << 1;
                            end
                        end else begin
                            if (pattern_q[0]) begin
                                pattern_d = pattern_q << 1;
                                dir_d     = DIR_UP;
                            end else begin
                                pattern_d = pattern_q >> 1;
                            end
                        end
                    end
                    MODE_ALL:   pattern_d = '1;
                endcase
            end
        end

        pwm_en = (&duty) || (pwm_q < duty);
        lit    = pattern_q & {NUM_LEDS{pwm_en}};
        led_d  = (ACTIVE_LOW != 0) ? ~lit : lit;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            pwm_q     <= '0;
            pattern_q <= '0;
            mode_q    <= MODE_COUNT;
            dir_q     <= DIR_UP;
            step_q    <= 1'b0;
            led_q     <= LED_OFF;
        end else begin
            presc_q   <= presc_d;
            pwm_q     <= pwm_d;
            pattern_q <= pattern_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            led_q     <= led_d;
        end
    end

    assign led  = led_q;
    assign step = step_q;

endmodule

// File: tb/tb_led_pattern_pwm.sv
// Self-checking bench for led_pattern_pwm: directed vector table, hand-written
// corner sequences and a randomized run against a step-count based reference model.
module tb_led_pattern_pwm;

    localparam int CLK_FREQ_HZ = 8;
    localparam int STEP_HZ     = 1;
    localparam int NUM_LEDS    = 4;
    localparam int PWM_BITS    = 3;
    localparam int ACTIVE_LOW  = 1;
    localparam int DIV         = CLK_FREQ_HZ / STEP_HZ;

    logic                clk;
    logic                rst;
    logic [1:0]          mode;
    logic [PWM_BITS-1:0] duty;
    logic                hold;
    logic [NUM_LEDS-1:0] led;
    logic                step;

    int n_checks = 0;
    int n_errors = 0;

    led_pattern_pwm #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .STEP_HZ    (STEP_HZ),
        .NUM_LEDS   (NUM_LEDS),
        .PWM_BITS   (PWM_BITS),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .duty (duty),
        .hold (hold),
        .led  (led),
        .step (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pattern is a function of the mode and the number of
    // steps taken since the last mode load.
    int         m_mode, m_k, m_presc, m_pwm;
    logic       m_step;
    logic [3:0] m_led;

    function automatic logic [3:0] ref_pattern(input int md, input int k);
        int pos;
        case (md)
            0: return 4'(k % 16);
            1: return 4'(1 << (k % NUM_LEDS));
            2: begin
                pos = k % (2 * (NUM_LEDS - 1));
                if (pos >= NUM_LEDS) pos = 2 * (NUM_LEDS - 1) - pos;
                return 4'(1 << pos);
            end
            default: return 4'hF;
        endcase
    endfunction

    function automatic bit ref_lit(input int cnt, input int d);
        return (d == 7) || (cnt < d);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode  <= 0;
            m_k     <= 0;
            m_presc <= 0;
            m_pwm   <= 0;
            m_step  <= 1'b0;
            m_led   <= 4'hF;
        end else begin
            m_led <= ~(ref_pattern(m_mode, m_k) & (ref_lit(m_pwm, int'(duty)) ? 4'hF : 4'h0));
            m_pwm <= (m_pwm + 1) % 8;
            if (int'(mode) != m_mode) begin
                m_mode  <= int'(mode);
                m_k     <= 0;
                m_presc <= 0;
                m_step  <= 1'b0;
            end else if (!hold && m_presc == DIV - 1) begin
                m_presc <= 0;
                m_k     <= m_k + 1;
                m_step  <= 1'b1;
            end else begin
                if (!hold) m_presc <= m_presc + 1;
                m_step <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [2:0] duty;
        logic       hold;
        int         cycles;
        logic [3:0] exp_led;
        logic       exp_step;
    } vec_t;

    vec_t vecs[20];

    initial begin
        int lows, bad, lit_cnt, step_seen;

        // Bounce from reset, then a switch to binary count.
        vecs[0]  = '{2'd2, 3'd7, 1'b0, 2, 4'b1110, 1'b0};
        vecs[1]  = '{2'd2, 3'd7, 1'b0, 7, 4'b1110, 1'b1};
        vecs[2]  = '{2'd2, 3'd7, 1'b0, 1, 4'b1101, 1'b0};
        vecs[3]  = '{2'd2, 3'd7, 1'b0, 7, 4'b1101, 1'b1};
        vecs[4]  = '{2'd2, 3'd7, 1'b0, 1, 4'b1011, 1'b0};
        vecs[5]  = '{2'd2, 3'd7, 1'b0, 7, 4'b1011, 1'b1};
        vecs[6]  = '{2'd2, 3'd7, 1'b0, 1, 4'b0111, 1'b0};
        vecs[7]  = '{2'd2, 3'd7, 1'b0, 7, 4'b0111, 1'b1};
        vecs[8]  = '{2'd2, 3'd7, 1'b0, 1, 4'b1011, 1'b0};
        vecs[9]  = '{2'd2, 3'd7, 1'b0, 7, 4'b1011, 1'b1};
        vecs[10] = '{2'd2, 3'd7, 1'b0, 1, 4'b1101, 1'b0};
        vecs[11] = '{2'd2, 3'd7, 1'b0, 7, 4'b1101, 1'b1};
        vecs[12] = '{2'd2, 3'd7, 1'b0, 1, 4'b1110, 1'b0};
        vecs[13] = '{2'd2, 3'd7, 1'b0, 7, 4'b1110, 1'b1};
        vecs[14] = '{2'd2, 3'd7, 1'b0, 1, 4'b1101, 1'b0};
        vecs[15] = '{2'd0, 3'd7, 1'b0, 2, 4'b1111, 1'b0};
        vecs[16] = '{2'd0, 3'd7, 1'b0, 7, 4'b1111, 1'b1};
        vecs[17] = '{2'd0, 3'd7, 1'b0, 1, 4'b1110, 1'b0};
        vecs[18] = '{2'd0, 3'd7, 1'b0, 7, 4'b1110, 1'b1};
        vecs[19] = '{2'd0, 3'd7, 1'b0, 1, 4'b1101, 1'b0};

        rst  = 1'b1;
        mode = 2'd2;
        duty = 3'd7;
        hold = 1'b0;
        repeat (3) cyc();
        check("reset_led", 32'(led), 32'hF);
        check("reset_step", 32'(step), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            mode = vecs[i].mode;
            duty = vecs[i].duty;
            hold = vecs[i].hold;
            repeat (vecs[i].cycles) cyc();
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
            check($sformatf("vec%0d_step", i), 32'(step), 32'(vecs[i].exp_step));
        end

        // All-on at low duty, then zero duty.
        mode = 2'd3;
        duty = 3'd2;
        cyc();
        lows = 0;
        bad  = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (led == 4'h0) lows++;
            else if (led != 4'hF) bad++;
        end
        check("duty2_low_cycles", 32'(lows), 32'd2);
        check("duty2_other_values", 32'(bad), 32'd0);
        duty = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("duty0_led", 32'(led), 32'hF);
        end

        // Hold freezes prescaler and pattern while PWM keeps running.
        mode = 2'd1;
        duty = 3'd7;
        cyc();
        repeat (3) cyc();
        hold = 1'b1;
        duty = 3'd4;
        step_seen = 0;
        bad       = 0;
        lit_cnt   = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (step) step_seen++;
            if (led != 4'b1110 && led != 4'b1111) bad++;
            if (i < 16 && led == 4'b1110) lit_cnt++;
        end
        check("hold_step_pulses", 32'(step_seen), 32'd0);
        check("hold_pattern_frozen", 32'(bad), 32'd0);
        check("hold_pwm_lit_cycles", 32'(lit_cnt), 32'd8);
        hold = 1'b0;
        duty = 3'd7;
        step_seen = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (step) step_seen++;
        end
        check("resume_early_step", 32'(step_seen), 32'd0);
        cyc();
        check("resume_step", 32'(step), 32'h1);
        check("resume_led_before", 32'(led), 32'b1110);
        cyc();
        check("resume_led_after", 32'(led), 32'b1101);

        // Mode change on the edge a step is due.
        mode = 2'd0;
        cyc();
        repeat (7) cyc();
        mode = 2'd1;
        cyc();
        check("chg_no_step", 32'(step), 32'h0);
        check("chg_led_old", 32'(led), 32'hF);
        cyc();
        check("chg_led_walk", 32'(led), 32'b1110);
        step_seen = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (step) step_seen++;
        end
        check("chg_prescaler_restart", 32'(step_seen), 32'd0);
        cyc();
        check("chg_first_step", 32'(step), 32'h1);
        cyc();
        check("chg_walk_led", 32'(led), 32'b1101);

        // Asynchronous reset while bouncing downward.
        mode = 2'd2;
        cyc();
        repeat (32) cyc();
        check("down_step", 32'(step), 32'h1);
        check("down_led", 32'(led), 32'b0111);
        #2 rst = 1'b1;
        #1;
        check("async_rst_led", 32'(led), 32'hF);
        check("async_rst_step", 32'(step), 32'h0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        check("post_rst_led", 32'(led), 32'b1110);
        repeat (7) cyc();
        check("post_rst_step", 32'(step), 32'h1);
        cyc();
        check("post_rst_up", 32'(led), 32'b1101);

        // Randomized run against the reference model.
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            check("rand_led", 32'(led), 32'(m_led));
            check("rand_step", 32'(step), 32'(m_step));
            if ($urandom_range(63) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) duty = 3'($urandom_range(7));
            if ($urandom_range(15) == 0) hold = ~hold;
            if ($urandom_range(499) == 0) begin
                #2 rst = 1'b1;
                #4 rst = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_pwm.md
LED_PATTERN_PWM -- requirements
Module: led_pattern_pwm

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 12000000, input clock frequency in Hz.
REQ-002 SHALL have parameter STEP_HZ, default 2, pattern step rate in Hz; DIV = CLK_FREQ_HZ/STEP_HZ (integer, >=2).
REQ-003 SHALL have parameter NUM_LEDS, default 8, LED channel count (>=2).
REQ-004 SHALL have parameter PWM_BITS, default 3, brightness resolution (1..8).
REQ-005 SHALL have parameter ACTIVE_LOW, default 1, 1 = LED lit by logic low.
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port mode  input  2  pattern select: 0 binary count, 1 walking one, 2 bounce, 3 all-on.
REQ-009 SHALL have port duty  input  PWM_BITS  brightness; 0 = off, all-ones = fully on.
REQ-010 SHALL have port hold  input  1  high freezes prescaler and pattern.
REQ-011 SHALL have port led  output  NUM_LEDS  registered LED drive, polarity per ACTIVE_LOW.
REQ-012 SHALL have port step  output  1  registered one-cycle pulse on each pattern advance.

Function
REQ-013 Prescaler SHALL count 0..DIV-1 and wrap to 0; it SHALL increment only when hold=0 and hold its value when hold=1.
REQ-014 Step event SHALL occur when prescaler = DIV-1 and hold=0; pattern SHALL update on that edge; step output SHALL be high the following cycle only.
REQ-015 Mode 0: pattern SHALL be a NUM_LEDS-bit up counter, +1 per step, wrapping all-ones -> 0.
REQ-016 Mode 1: pattern SHALL hold exactly one set bit, shifting from bit i to i+1 per step, bit NUM_LEDS-1 -> bit 0.
REQ-017 Mode 2: FSM states UP and DOWN; UP shifts the single bit toward MSB, DOWN toward LSB; at bit NUM_LEDS-1 in UP the next step SHALL go to bit NUM_LEDS-2 and state DOWN; at bit 0 in DOWN the next step SHALL go to bit 1 and state UP; no end bit is repeated.
REQ-018 Mode 3: pattern SHALL be all-ones; step events SHALL still pulse step.
REQ-019 mode value SHALL be registered; when the registered mode changes, pattern SHALL load the new mode's start value (mode 0: 0; 1 and 2: 'b1 with FSM=UP; 3: all-ones) on the next edge, and prescaler SHALL reset to 0; mode change SHALL take priority over a simultaneous step.
REQ-020 PWM counter SHALL be PWM_BITS wide, free-running, unaffected by hold, wrapping to 0.
REQ-021 PWM enable SHALL be 1 when duty is all-ones or pwm_cnt < duty, else 0.
REQ-022 lit = pattern AND {NUM_LEDS{enable}}; led SHALL equal ~lit if ACTIVE_LOW=1 else lit, registered one cycle after pattern/pwm_cnt.
REQ-023 duty SHALL be sampled every cycle without a handshake; change takes effect on the next PWM compare.

Reset
REQ-024 On rst=1, asynchronously: prescaler=0, pwm_cnt=0, pattern=0, registered mode=0, FSM=UP, step=0, led all-off (all-ones if ACTIVE_LOW=1, zeros otherwise).
REQ-025 After rst deasserts, the first edge SHALL perform the REQ-019 mode-change load if input mode != 0; the first step SHALL occur DIV cycles after the load.
REQ-026 rst asserted mid-pattern SHALL discard all state; no partial step pulse is emitted.

Verification
REQ-027 CLK_FREQ_HZ=8, STEP_HZ=1, NUM_LEDS=4, PWM_BITS=3, ACTIVE_LOW=1; mode=0, duty=7 -> led = ~pattern, pattern 0,1,2,...,15,0 every 8 cycles, step pulsed once per 8 cycles.
REQ-028 Same params, mode=2, duty=7 -> pattern 0001,0010,0100,1000,0100,0010,0001,0010 across 7 steps.
REQ-029 mode=3, duty=2 -> each LED low for exactly 2 of every 8 cycles (pwm_cnt 0,1); duty=0 -> led stays 1111.
REQ-030 mode=1, hold=1 for 20 cycles mid-count -> pattern and prescaler frozen, step stays 0, PWM continues; hold=0 resumes from frozen prescaler value.
REQ-031 mode changes 0->1 on the same edge a step is due -> pattern=0001, prescaler=0, no step pulse.
REQ-032 rst pulsed asynchronously between clock edges during mode 2 DOWN -> led=1111 immediately, step=0, FSM=UP on release.
